cis_line_capture: RTL and testbench

Pixel-capture stage directly downstream of the CIS timing controller. Watches the controller's SI / SI_TOGGLE / SI_CNT outputs and the sensor ADC sample stream, and frames each real sensor line into a tagged pixel stream. Fake (flush) SI pulses are discarded. Output goes through a small FIFO with a valid/ready handshake toward the line-buffer / USB packer stage.

---
 rtl/cis_pkg.sv | 25 ++
 rtl/cis_capture_fifo.sv | 46 ++++
 rtl/cis_line_capture.sv | 194 +++++++++++++++++++
 tb/tb_cis_line_capture.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cis_pkg.sv
// Shared definitions for the CIS line-capture stage: color codes, default line
// length, capture FSM states and the tag half of the FIFO word {sol, eol, color, data}.
package cis_pkg;

    localparam logic [1:0] CIS_R = 2'd0;
    localparam logic [1:0] CIS_G = 2'd1;
    localparam logic [1:0] CIS_B = 2'd2;

    localparam int CIS_PIX_CNT = 2592;
    localparam int CIS_TAG_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPT
    } cis_state_t;

    // Upper bits of every FIFO word; the sample itself sits below in DATA_W bits.
    typedef struct packed {
        logic       sol;
        logic       eol;
        logic [1:0] color;
    } cis_tag_t;

endpackage

// File: rtl/cis_capture_fifo.sv
// First-word-fall-through synchronous FIFO between the capture FSM and the
// downstream packer; a write while full is simply not stored.
module cis_capture_fifo #(
    parameter int W  = 20,
    parameter int AW = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);

    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/cis_line_capture.sv
// Frames real CIS sensor lines into a tagged pixel stream behind a FWFT FIFO.
// Define CIS_CAPTURE_TEST_PATTERN_EN to replace ADC data by {color, pixel index}.
module cis_line_capture
    import cis_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int PIX_CNT  = CIS_PIX_CNT,
    parameter int SKIP_CNT = 12,
    parameter int FIFO_AW  = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SI,
    input  logic              SI_TOGGLE,
    input  logic [1:0]        SI_CNT,
    input  logic [DATA_W-1:0] ADC_DATA,
    input  logic              ADC_VALID,
    output logic [DATA_W-1:0] M_DATA,
    output logic [1:0]        M_COLOR,
    output logic              M_SOL,
    output logic              M_EOL,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [15:0]       LINE_NUM,
    output logic              OVERFLOW,
    output logic [7:0]        SHORT_LINES
);

    localparam int PCW_MIN = (PIX_CNT > 1) ? $clog2(PIX_CNT) : 1;
    localparam int PCW     = (PCW_MIN > DATA_W - 2) ? PCW_MIN : DATA_W - 2;
    localparam int SCW     = (SKIP_CNT > 1) ? $clog2(SKIP_CNT) : 1;
    localparam int WW      = DATA_W + CIS_TAG_W;

    logic              si_r;
    logic              si_d;
    logic              tog_r;
    logic [1:0]        cnt_r;
    logic              tog_last;
    logic [1:0]        color;
    logic              real_start;
    cis_state_t        state;
    cis_state_t        state_nxt;
    logic [PCW-1:0]    pix_cnt;
    logic [SCW-1:0]    skip_cnt;
    logic              cap_write;
    logic              is_eol;
    logic              line_done;
    logic              abort;
    logic [DATA_W-1:0] cap_data;
    cis_tag_t          cap_tag;
    logic              wr_en_q;
    logic [WW-1:0]     wr_word_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WW-1:0]     fifo_word;
    logic [WW-1:0]     out_word;
    cis_tag_t          out_tag;
    logic [15:0]       line_num;
    logic [7:0]        short_lines;
    logic              overflow;

    // SI and its companions are registered together so the toggle and color
    // seen at the detected rise are the ones that accompanied the pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            si_r  <= 1'b0;
            si_d  <= 1'b0;
            tog_r <= 1'b0;
            cnt_r <= CIS_R;
        end else begin
            si_r  <= SI;
            si_d  <= si_r;
            tog_r <= SI_TOGGLE;
            cnt_r <= SI_CNT;
        end
    end

    assign real_start = si_r && !si_d && (tog_r != tog_last);
    assign is_eol     = (pix_cnt == PCW'(PIX_CNT - 1));

    always_comb begin
        state_nxt = state;
        cap_write = 1'b0;
        line_done = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_SKIP: begin
                if (ADC_VALID && (skip_cnt == SCW'(SKIP_CNT - 1))) begin
                    state_nxt = ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (ADC_VALID) begin
                    cap_write = 1'b1;
                    if (is_eol) begin
                        line_done = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A new start wins over everything; a line finishing this cycle is not short.
        if (real_start) begin
            abort     = (state != ST_IDLE) && !line_done;
            state_nxt = (SKIP_CNT == 0) ? ST_CAPT : ST_SKIP;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            tog_last    <= 1'b0;
            color       <= CIS_R;
            pix_cnt     <= '0;
            skip_cnt    <= '0;
            line_num    <= '0;
            short_lines <= '0;
        end else begin
            state <= state_nxt;
            if (real_start) begin
                tog_last <= tog_r;
                color    <= cnt_r;
                pix_cnt  <= '0;
                skip_cnt <= '0;
            end else begin
                if ((state == ST_SKIP) && ADC_VALID) begin
                    skip_cnt <= skip_cnt + SCW'(1);
                end
                if (cap_write) begin
                    pix_cnt <= pix_cnt + PCW'(1);
                end
            end
            if (line_done) begin
                line_num <= line_num + 16'd1;
            end
            if (abort && (short_lines != 8'hFF)) begin
                short_lines <= short_lines + 8'd1;
            end
        end
    end

`ifdef CIS_CAPTURE_TEST_PATTERN_EN
    assign cap_data = {color, pix_cnt[DATA_W-3:0]};
`else
    assign cap_data = ADC_DATA;
`endif

    assign cap_tag = '{sol: (pix_cnt == '0), eol: is_eol, color: color};

    // One register stage before the FIFO; a full FIFO here drops the word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_en_q   <= 1'b0;
            wr_word_q <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_en_q <= cap_write;
            if (cap_write) begin
                wr_word_q <= {cap_tag, cap_data};
            end
            if (wr_en_q && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    cis_capture_fifo #(
        .W  (WW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (wr_en_q),
        .wr_data (wr_word_q),
        .full    (fifo_full),
        .rd_en   (M_READY),
        .rd_data (fifo_word),
        .empty   (fifo_empty)
    );

    assign out_word    = fifo_empty ? '0 : fifo_word;
    assign out_tag     = cis_tag_t'(out_word[WW-1:DATA_W]);
    assign M_DATA      = out_word[DATA_W-1:0];
    assign M_COLOR     = out_tag.color;
    assign M_SOL       = out_tag.sol;
    assign M_EOL       = out_tag.eol;
    assign M_VALID     = !fifo_empty;
    assign LINE_NUM    = line_num;
    assign OVERFLOW    = overflow;
    assign SHORT_LINES = short_lines;

endmodule

// File: tb/tb_cis_line_capture.sv
// Randomized scoreboard bench for cis_line_capture: a line-level model predicts
// every output beat and the status counters from the stimulus it issues.
module tb_cis_line_capture;

    localparam int DATA_W = 16;
    localparam int PIX    = 2592;
    localparam int SKIP   = 12;
    localparam int AW     = 6;
    localparam int DEPTH  = 2**AW;

    logic              CLK = 1'b0;
    logic              RST;
    logic              SI;
    logic              SI_TOGGLE;
    logic [1:0]        SI_CNT;
    logic [DATA_W-1:0] ADC_DATA;
    logic              ADC_VALID;
    logic [DATA_W-1:0] M_DATA;
    logic [1:0]        M_COLOR;
    logic              M_SOL;
    logic              M_EOL;
    logic              M_VALID;
    logic              M_READY;
    logic [15:0]       LINE_NUM;
    logic              OVERFLOW;
    logic [7:0]        SHORT_LINES;

    always #5 CLK = ~CLK;

    cis_line_capture #(
        .DATA_W   (DATA_W),
        .PIX_CNT  (PIX),
        .SKIP_CNT (SKIP),
        .FIFO_AW  (AW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SI          (SI),
        .SI_TOGGLE   (SI_TOGGLE),
        .SI_CNT      (SI_CNT),
        .ADC_DATA    (ADC_DATA),
        .ADC_VALID   (ADC_VALID),
        .M_DATA      (M_DATA),
        .M_COLOR     (M_COLOR),
        .M_SOL       (M_SOL),
        .M_EOL       (M_EOL),
        .M_VALID     (M_VALID),
        .M_READY     (M_READY),
        .LINE_NUM    (LINE_NUM),
        .OVERFLOW    (OVERFLOW),
        .SHORT_LINES (SHORT_LINES)
    );

    typedef struct packed {
        logic              sol;
        logic              eol;
        logic [1:0]        color;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Line-level model state: position within the current line, counters, start bookkeeping.
    bit         line_active;
    int         line_idx;
    logic [1:0] line_color;
    logic       tog_last_m;
    int         exp_lines;
    int         exp_short;
    logic       exp_ovf;
    bit         pend_start;
    logic [1:0] pend_color;
    logic       pend_tog;
    bit         stall_mode;
    int         stall_stored;
    bit         ready_rand;
    bit         ready_low;
    logic       cur_tog;
    logic [1:0] cur_cnt;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        line_active = 0;
        line_idx    = 0;
        line_color  = 2'd0;
        tog_last_m  = 1'b0;
        exp_lines   = 0;
        exp_short   = 0;
        exp_ovf     = 1'b0;
        pend_start  = 0;
    endtask

    task automatic model_sample(input logic [DATA_W-1:0] d);
        beat_t b;
        int    p;
        if (!line_active) return;
        if (line_idx >= SKIP) begin
            p       = line_idx - SKIP;
            b.sol   = (p == 0);
            b.eol   = (p == PIX - 1);
            b.color = line_color;
`ifdef CIS_CAPTURE_TEST_PATTERN_EN
            b.data  = {line_color, 14'(p)};
`else
            b.data  = d;
`endif
            if (stall_mode && stall_stored >= DEPTH) begin
                exp_ovf = 1'b1;
            end else begin
                exp_q.push_back(b);
                if (stall_mode) stall_stored++;
            end
            if (p == PIX - 1) begin
                exp_lines++;
                line_active = 0;
            end
        end
        line_idx++;
    endtask

    task automatic model_start();
        if (line_active && exp_short < 255) exp_short++;
        line_active = 1;
        line_idx    = 0;
        line_color  = pend_color;
        tog_last_m  = pend_tog;
    endtask

    // One clock of stimulus; the sample of this cycle belongs to the old line
    // and a start seen on SI last cycle takes effect after it.
    task automatic apply_stimulus(input logic si, input logic tog, input logic [1:0] cnt,
                                  input logic valid, input logic [DATA_W-1:0] data);
        @(posedge CLK);
        #1;
        SI        = si;
        SI_TOGGLE = tog;
        SI_CNT    = cnt;
        ADC_VALID = valid;
        ADC_DATA  = data;
        M_READY   = ready_low ? 1'b0 : (ready_rand ? ($urandom_range(7) != 0) : 1'b1);
        if (valid) model_sample(data);
        if (pend_start) model_start();
        pend_start = 0;
        if (si && (tog != tog_last_m)) begin
            pend_start = 1;
            pend_color = cnt;
            pend_tog   = tog;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, cur_tog, cur_cnt, 1'b0, '0);
    endtask

    task automatic start_line(input logic [1:0] color, input bit is_real);
        cur_cnt = color;
        cur_tog = is_real ? ~tog_last_m : tog_last_m;
        apply_stimulus(1'b1, cur_tog, cur_cnt, 1'b0, '0);
        apply_stimulus(1'b0, cur_tog, cur_cnt, 1'b0, '0);
    endtask

    task automatic samples(input int n, input int rate);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) >= rate) apply_stimulus(1'b0, cur_tog, cur_cnt, 1'b0, '0);
            apply_stimulus(1'b0, cur_tog, cur_cnt, 1'b1, DATA_W'($urandom));
        end
    endtask

    task automatic drain();
        int budget = 10000;
        while (exp_q.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        idle(4);
        check_output("drain_pending_beats", exp_q.size(), 0);
    endtask

    task automatic check_counters(input string tag);
        check_output({tag, "_line_num"}, LINE_NUM, exp_lines[15:0]);
        check_output({tag, "_short_lines"}, SHORT_LINES, exp_short[7:0]);
        check_output({tag, "_overflow"}, OVERFLOW, exp_ovf);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge CLK);
        check_output({tag, "_m_valid"}, M_VALID, 0);
        check_output({tag, "_m_data"}, M_DATA, 0);
        check_output({tag, "_m_color"}, M_COLOR, 0);
        check_output({tag, "_m_sol_eol"}, {M_SOL, M_EOL}, 0);
        check_output({tag, "_line_num"}, LINE_NUM, 0);
        check_output({tag, "_overflow"}, OVERFLOW, 0);
        check_output({tag, "_short_lines"}, SHORT_LINES, 0);
    endtask

    // Monitor: every accepted beat must match the oldest predicted beat.
    always @(negedge CLK) begin : monitor
        beat_t got;
        beat_t exp;
        if (!RST && M_VALID && M_READY) begin
            got = {M_SOL, M_EOL, M_COLOR, M_DATA};
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_beat: got %0h expected no beat", got);
            end else begin
                exp = exp_q.pop_front();
                check_output("beat", got, exp);
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d beats still expected", exp_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b1; SI = 1'b0; SI_TOGGLE = 1'b0; SI_CNT = 2'd0;
        ADC_DATA = '0; ADC_VALID = 1'b0; M_READY = 1'b1;
        ready_rand = 0; ready_low = 0; stall_mode = 0; stall_stored = 0;
        cur_tog = 1'b0; cur_cnt = 2'd0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check_reset_outputs("reset");

        // Three full-rate lines R, G, B back to back.
        for (int c = 0; c < 3; c++) begin
            start_line(2'(c), 1);
            samples(SKIP + PIX, 100);
        end
        drain();
        check_counters("continuous");
        check_output("continuous_three_lines", LINE_NUM, 3);

        // Fake SI (no toggle change) then stray samples in IDLE: nothing may come out.
        start_line(2'd2, 0);
        samples(20, 100);
        drain();
        check_counters("fake_start");

        // Line aborted after 1000 pixels by a new real start, then a complete line.
        ready_rand = 1;
        start_line(2'd0, 1);
        samples(SKIP + 1000, 50);
        start_line(2'd1, 1);
        samples(SKIP + PIX, 50);
        ready_rand = 0;
        drain();
        check_counters("aborted");
        check_output("aborted_short_one", SHORT_LINES, 1);

        // Downstream stalled for about 200 cycles mid-line: only DEPTH words survive.
        start_line(2'd2, 1);
        samples(SKIP + 100, 100);
        drain();
        ready_low = 1; stall_mode = 1; stall_stored = 0;
        samples(150, 100);
        idle(50);
        check_output("stall_overflow", OVERFLOW, exp_ovf);
        ready_low = 0; stall_mode = 0;
        drain();
        samples(PIX - 250, 100);
        start_line(2'd0, 1);
        samples(SKIP + PIX, 100);
        drain();
        check_counters("after_stall");

        // EOL sample coincides with the cycle a new real start is detected.
        start_line(2'd1, 1);
        samples(SKIP + PIX - 2, 100);
        cur_tog = ~tog_last_m; cur_cnt = 2'd2;
        apply_stimulus(1'b1, cur_tog, cur_cnt, 1'b1, DATA_W'($urandom));
        apply_stimulus(1'b0, cur_tog, cur_cnt, 1'b1, DATA_W'($urandom));
        samples(SKIP + PIX, 100);
        drain();
        check_counters("eol_with_start");

        // Reset in the middle of a line; the next line must start cleanly with SOL.
        start_line(2'd0, 1);
        samples(SKIP + 500, 100);
        ready_low = 1;
        idle(4);
        @(posedge CLK);
        #1 RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1 RST = 1'b0;
        check_reset_outputs("mid_line_reset");
        ready_low = 0;
        start_line(2'd1, 1);
        samples(SKIP + PIX, 100);
        drain();
        check_counters("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
